// File: rtl/seven_seg_scan_ctrl_if.sv
// Load port of the 7-segment scan controller: valid/ready value load plus the
// transfer-complete pulse.
interface seven_seg_scan_ctrl_if;
  logic        load;
  logic        load_ready;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        upd_done;

  modport master (
    output load, value, dp_in,
    input  load_ready, upd_done
  );

  modport slave (
    input  load, value, dp_in,
    output load_ready, upd_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display
// with a double-buffered value, blanking gaps between digits and registered outputs.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scan_ctrl_if.slave bus,
  input  logic [3:0]           digit_en,
  output logic [3:0]           seg_an,
  output logic [7:0]           seg_cat
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_d;
  logic [7:0]       cat_d;

  logic [15:0] act_val, pend_val;
  logic [3:0]  act_dp, pend_dp;
  logic        pend_full;
  logic        upd_done_q;

  logic slot_end;
  logic frame_end;
  logic accept;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign accept    = bus.load && !pend_full;

  assign bus.load_ready = !pend_full;
  assign bus.upd_done   = upd_done_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    an_d    = 4'hF;
    cat_d   = 8'hFF;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    // The state always tracks the counter value it is paired with.
    state_d = (cnt_d >= BLANK_END) ? ST_DRIVE : ST_BLANK;
    if (state_q == ST_DRIVE) begin
      if (digit_en[idx_q]) an_d = ~(4'b0001 << idx_q);
      cat_d = {~act_dp[idx_q], decode(act_val[4*idx_q +: 4])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      seg_an  <= 4'hF;
      seg_cat <= 8'hFF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_an  <= an_d;
      seg_cat <= cat_d;
    end
  end

  // Swapping only at the frame boundary keeps every frame from a single value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      upd_done_q <= 1'b0;
      if (frame_end && pend_full) begin
        act_val    <= pend_val;
        act_dp     <= pend_dp;
        pend_full  <= 1'b0;
        upd_done_q <= 1'b1;
      end else if (accept) begin
        pend_val  <= bus.value;
        pend_dp   <= bus.dp_in;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2;
// g counts rising edges since reset release, outputs at g show the slot state of g-1.
module tb_seven_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_en;
  logic [3:0] seg_an;
  logic [7:0] seg_cat;

  int total = 0;
  int bad   = 0;
  int g     = 0;
  int low_cnt[4];
  int bad_an_seen;

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .digit_en (digit_en),
    .seg_an   (seg_an),
    .seg_cat  (seg_cat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (g=%0d)", tag, obs, exp, g);
    end
  endtask

  function automatic logic [7:0] dec(input logic [3:0] nib);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[nib];
  endfunction

  function automatic logic [3:0] exp_an(input int q, input logic [3:0] en);
    int ph = q % 8;
    int id = (q / 8) % 4;
    if (ph >= 2 && en[id]) return ~(4'b0001 << id);
    return 4'hF;
  endfunction

  function automatic logic [7:0] exp_cat(input int q, input logic [15:0] v, input logic [3:0] dp);
    int ph = q % 8;
    int id = (q / 8) % 4;
    logic [7:0] c;
    if (ph < 2) return 8'hFF;
    c = dec(v[4*id +: 4]);
    c[7] = ~dp[id];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    g++;
    @(negedge clk);
  endtask

  // Checks n cycles against the expected display and counts anode-low cycles.
  task automatic check_frame(input int n, input logic [15:0] v, input logic [3:0] dp);
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    bad_an_seen = 0;
    for (int k = 0; k < n; k++) begin
      step();
      check("seg_an", seg_an, exp_an(g - 1, digit_en));
      check("seg_cat", seg_cat, exp_cat(g - 1, v, dp));
      check("upd_idle", bus.upd_done, 1'b0);
      for (int i = 0; i < 4; i++) if (!seg_an[i]) low_cnt[i]++;
      if (seg_an == 4'b1110 || seg_an == 4'b1011) bad_an_seen++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = dp;
    step();
    bus.load = 1'b0;
    check("ready_drop", bus.load_ready, 1'b0);
  endtask

  task automatic wait_upd(input int exp_g);
    logic seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      step();
      if (bus.upd_done) seen = 1'b1;
    end
    check("upd_seen", seen, 1'b1);
    check("upd_time", g, exp_g);
    check("ready_back", bus.load_ready, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    digit_en  = 4'hF;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    repeat (2) @(negedge clk);
    check("rst_an", seg_an, 4'hF);
    check("rst_cat", seg_cat, 8'hFF);
    check("rst_ready", bus.load_ready, 1'b1);
    check("rst_upd", bus.upd_done, 1'b0);
    rst_n = 1'b1;
    g = 0;

    // 1: zeros on all digits, 6 anode-low cycles per slot
    check_frame(32, 16'h0000, 4'h0);
    for (int i = 0; i < 4; i++) check("low_cycles", low_cnt[i], 6);

    // 2: 1234 appears after the frame boundary
    do_load(16'h1234, 4'h0);
    wait_upd(64);
    check_frame(32, 16'h1234, 4'h0);

    // 3: second load while busy is ignored, then re-sent
    do_load(16'hABCD, 4'h0);
    bus.load  = 1'b1;
    bus.value = 16'h0F0F;
    repeat (3) step();
    bus.load = 1'b0;
    check("busy_ready", bus.load_ready, 1'b0);
    wait_upd(128);
    check_frame(32, 16'hABCD, 4'h0);
    do_load(16'h0F0F, 4'h0);
    wait_upd(192);
    check_frame(32, 16'h0F0F, 4'h0);

    // 4: decimal point on digit 2 only
    do_load(16'h8888, 4'b0100);
    bus.dp_in = 4'h0;
    wait_upd(256);
    check_frame(32, 16'h8888, 4'b0100);

    // 5: digits 0 and 2 disabled
    digit_en = 4'b1010;
    check_frame(32, 16'h8888, 4'b0100);
    check("no_an_0_2", bad_an_seen, 0);
    check("dark_d0", low_cnt[0], 0);
    check("dark_d2", low_cnt[2], 0);
    check("lit_d1", low_cnt[1], 6);

    // 6: reset mid-DRIVE with pending full
    digit_en = 4'hF;
    do_load(16'h5555, 4'h0);
    repeat (3) step();
    check("pre_rst_an", seg_an, 4'b1110);
    check("pre_rst_cat", seg_cat, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", seg_an, 4'hF);
    check("mid_rst_cat", seg_cat, 8'hFF);
    check("mid_rst_ready", bus.load_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    g = 0;
    check("post_rst_ready", bus.load_ready, 1'b1);
    check_frame(36, 16'h0000, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
